// File: rtl/led_pattern_sched_if.sv
// Host configuration handshake for led_pattern_sched.
// The host (master) holds cfg_wr with channel, mode and phase until the
// scheduler (slave) answers with a one-cycle cfg_ack.
interface led_pattern_sched_if #(
  parameter int NUM_CH         = 4,
  parameter int LUT_ADDR_WIDTH = 8
);
  localparam int CH_W = $clog2(NUM_CH);

  logic                      cfg_wr;
  logic [CH_W-1:0]           cfg_ch;
  logic [1:0]                cfg_mode;
  logic [LUT_ADDR_WIDTH-1:0] cfg_phase;
  logic                      cfg_ack;

  modport master (output cfg_wr, cfg_ch, cfg_mode, cfg_phase, input cfg_ack);
  modport slave  (input cfg_wr, cfg_ch, cfg_mode, cfg_phase, output cfg_ack);
endinterface

// File: rtl/led_pattern_sched.sv
// led_pattern_sched: multi-channel LED pattern scheduler.
// One registered brightness ROM is shared by NUM_CH channels. A free-running
// prescaler produces a step tick; each tick advances BREATHE phases and starts
// a round-robin sweep that reads the ROM once per channel and registers one
// PWM duty value per channel.
// Optional feature: define LED_SCHED_SYNC_EN to add the in_sync input, which
// restarts the prescaler and realigns every phase to its last written value.
module led_pattern_sched #(
  parameter int NUM_CH         = 4,
  parameter int LUT_ADDR_WIDTH = 8,
  parameter int LUT_DATA_WIDTH = 8,
  parameter int STEP_DIV_WIDTH = 16
) (
  input  logic                               in_clk,
  input  logic                               in_rst_n,
`ifdef LED_SCHED_SYNC_EN
  input  logic                               in_sync,
`endif
  led_pattern_sched_if.slave                 cfg,
  output logic [LUT_ADDR_WIDTH-1:0]          out_lut_addr,
  input  logic [LUT_DATA_WIDTH-1:0]          in_lut_data,
  output logic [NUM_CH*LUT_DATA_WIDTH-1:0]   out_pwm_val,
  output logic                               out_sweep_done
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SWEEP = 2'b01,
    ST_DRAIN = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_t;

  state_t                    state_q, state_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [STEP_DIV_WIDTH-1:0] prescaler_q, prescaler_d;
  mode_t                     mode_q  [NUM_CH];
  mode_t                     mode_d  [NUM_CH];
  logic [LUT_ADDR_WIDTH-1:0] phase_q [NUM_CH];
  logic [LUT_ADDR_WIDTH-1:0] phase_d [NUM_CH];
  logic [LUT_DATA_WIDTH-1:0] pwm_q   [NUM_CH];
  logic [LUT_ADDR_WIDTH-1:0] lut_addr_q, lut_addr_d;
  logic                      cap_valid_q;
  logic [CH_W-1:0]           cap_ch_q;
  logic                      done_q;

  logic tick;
  logic sync_apply;
  logic wr_apply;
  logic ch_valid;

`ifdef LED_SCHED_SYNC_EN
  logic [LUT_ADDR_WIDTH-1:0] wr_phase_q [NUM_CH];
  logic [LUT_ADDR_WIDTH-1:0] wr_phase_d [NUM_CH];
  logic                      sync_pend_q, sync_pend_d;
  logic                      sync_req;

  // A sync seen outside IDLE is remembered and applied on return to IDLE.
  always_comb begin
    sync_req    = in_sync | sync_pend_q;
    sync_apply  = sync_req & (state_q == ST_IDLE);
    sync_pend_d = sync_req & ~sync_apply;
  end
`else
  assign sync_apply = 1'b0;
`endif

  assign tick     = &prescaler_q;
  assign ch_valid = int'(cfg.cfg_ch) < NUM_CH;
  // Writes land only in IDLE and lose to a same-cycle sync; an out-of-range
  // channel is still acknowledged so the host never stalls.
  assign wr_apply    = cfg.cfg_wr & (state_q == ST_IDLE) & ~sync_apply;
  assign cfg.cfg_ack = wr_apply & in_rst_n;

  // Sweep sequencing: a tick in IDLE starts a pass over all channels, then one
  // DRAIN cycle lets the last ROM read come back.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      ST_IDLE: begin
        if (tick && !sync_apply) begin
          state_d = ST_SWEEP;
          ch_d    = '0;
        end
      end
      ST_SWEEP: begin
        if (ch_q == LAST_CH) begin
          state_d = ST_DRAIN;
          ch_d    = '0;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ch_d    = '0;
      end
    endcase
  end

  // Per-channel mode/phase update: sync realigns, tick advances BREATHE, and a
  // config write overrides both so the loaded phase is not stepped this cycle.
  always_comb begin
    prescaler_d = sync_apply ? '0 : prescaler_q + 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      mode_d[i]  = mode_q[i];
      phase_d[i] = phase_q[i];
`ifdef LED_SCHED_SYNC_EN
      wr_phase_d[i] = wr_phase_q[i];
      if (sync_apply) begin
        phase_d[i] = wr_phase_q[i];
      end else
`endif
      if (tick && mode_q[i] == MODE_BREATHE) begin
        phase_d[i] = phase_q[i] + 1'b1;
      end
      if (wr_apply && ch_valid && int'(cfg.cfg_ch) == i) begin
        mode_d[i]  = mode_t'(cfg.cfg_mode);
        phase_d[i] = cfg.cfg_phase;
`ifdef LED_SCHED_SYNC_EN
        wr_phase_d[i] = cfg.cfg_phase;
`endif
      end
    end
  end

  // The ROM address is registered from next-cycle values so channel i's
  // address is on the pins during the i-th SWEEP cycle.
  assign lut_addr_d = (state_d == ST_SWEEP) ? phase_d[ch_d] : '0;

  // FSM state and sweep channel counter.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // Prescaler, channel configuration and ROM address registers.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      prescaler_q <= '0;
      lut_addr_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]  <= MODE_OFF;
        phase_q[i] <= '0;
      end
    end else begin
      prescaler_q <= prescaler_d;
      lut_addr_q  <= lut_addr_d;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]  <= mode_d[i];
        phase_q[i] <= phase_d[i];
      end
    end
  end

`ifdef LED_SCHED_SYNC_EN
  // Last written phase per channel and the pending-sync flag.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      sync_pend_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        wr_phase_q[i] <= '0;
      end
    end else begin
      sync_pend_q <= sync_pend_d;
      for (int i = 0; i < NUM_CH; i++) begin
        wr_phase_q[i] <= wr_phase_d[i];
      end
    end
  end
`endif

  // Capture runs one cycle behind issue to match the ROM read latency; the
  // mode chooses between a fixed level and the ROM value.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      cap_valid_q <= 1'b0;
      cap_ch_q    <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_q[i] <= '0;
      end
    end else begin
      cap_valid_q <= (state_q == ST_SWEEP);
      cap_ch_q    <= ch_q;
      done_q      <= (state_q == ST_DRAIN);
      if (cap_valid_q) begin
        case (mode_q[cap_ch_q])
          MODE_OFF: pwm_q[cap_ch_q] <= '0;
          MODE_ON:  pwm_q[cap_ch_q] <= '1;
          default:  pwm_q[cap_ch_q] <= in_lut_data;
        endcase
      end
    end
  end

  assign out_lut_addr   = lut_addr_q;
  assign out_sweep_done = done_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign out_pwm_val[g*LUT_DATA_WIDTH +: LUT_DATA_WIDTH] = pwm_q[g];
  end

endmodule
